// File: rtl/deb_pkg.sv
// Shared defaults and helpers for the debounced-input event capture stage.
package deb_pkg;

    localparam int   DEB_N_CH    = 8;
    localparam int   DEB_CNT_W   = 16;
    localparam logic DEB_RST_VAL = 1'b1;

    // Bit offset of channel i inside the packed counter bus.
    function automatic int cnt_slice(input int i, input int w = DEB_CNT_W);
        return i * w;
    endfunction

endpackage

// File: rtl/deb_event_ch.sv
// One capture channel: level history, qualified edge detect, sticky W1C status,
// saturating edge counter and its sticky overflow flag.
module deb_event_ch
    import deb_pkg::*;
#(
    parameter int   CNT_W   = DEB_CNT_W,
    parameter logic RST_VAL = DEB_RST_VAL
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             lvl,
    input  logic             rise_en,
    input  logic             fall_en,
    input  logic             clr,
    input  logic             cnt_clr,
    output logic             lvl_q,
    output logic             status,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic rise;
    logic fall;
    logic ev;
    logic cnt_full;

    assign rise     = lvl & ~lvl_q;
    assign fall     = ~lvl & lvl_q;
    assign ev       = (rise & rise_en) | (fall & fall_en);
    assign cnt_full = &cnt;

    // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lvl_q  <= RST_VAL;
            status <= 1'b0;
        end else begin
            lvl_q  <= lvl;
            // Set beats the W1C strobe so an event arriving with a clear is never lost.
            status <= ev | (status & ~clr);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (cnt_clr) begin
            cnt <= {{(CNT_W-1){1'b0}}, ev};
            ovf <= 1'b0;
        end else if (ev) begin
            if (cnt_full) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/deb_event.sv
// Multi-channel edge/event capture: one deb_event_ch per input plus a registered,
// maskable interrupt built from the sticky status bits.
module deb_event
    import deb_pkg::*;
#(
    parameter int   N_CH    = DEB_N_CH,
    parameter int   CNT_W   = DEB_CNT_W,
    parameter logic RST_VAL = DEB_RST_VAL
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_CH-1:0]       lvl,
    input  logic [N_CH-1:0]       rise_en,
    input  logic [N_CH-1:0]       fall_en,
    input  logic [N_CH-1:0]       irq_mask,
    input  logic [N_CH-1:0]       clr,
    input  logic [N_CH-1:0]       cnt_clr,
    output logic [N_CH-1:0]       lvl_q,
    output logic [N_CH-1:0]       status,
    output logic [N_CH*CNT_W-1:0] cnt,
    output logic [N_CH-1:0]       ovf,
    output logic                  irq
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        deb_event_ch #(
            .CNT_W   (CNT_W),
            .RST_VAL (RST_VAL)
        ) u_ch (
            .clk     (clk),
            .rstn    (rstn),
            .lvl     (lvl[i]),
            .rise_en (rise_en[i]),
            .fall_en (fall_en[i]),
            .clr     (clr[i]),
            .cnt_clr (cnt_clr[i]),
            .lvl_q   (lvl_q[i]),
            .status  (status[i]),
            .cnt     (cnt[cnt_slice(i, CNT_W) +: CNT_W]),
            .ovf     (ovf[i])
        );
    end

    // Built from the registered status, so irq trails the status flop by one clock.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq <= 1'b0;
        end else begin
            irq <= |(status & irq_mask);
        end
    end

endmodule

// File: tb/tb_deb_event.sv
// Self-checking bench for deb_event: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural per-channel event model.
module tb_deb_event;

    localparam int N_CH  = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                  clk;
    logic                  rstn;
    logic [N_CH-1:0]       lvl;
    logic [N_CH-1:0]       rise_en;
    logic [N_CH-1:0]       fall_en;
    logic [N_CH-1:0]       irq_mask;
    logic [N_CH-1:0]       clr;
    logic [N_CH-1:0]       cnt_clr;
    logic [N_CH-1:0]       lvl_q;
    logic [N_CH-1:0]       status;
    logic [N_CH*CNT_W-1:0] cnt;
    logic [N_CH-1:0]       ovf;
    logic                  irq;

    int n_pass   = 0;
    int n_checks = 0;
    bit cmp_en   = 0;

    deb_event #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .RST_VAL (1'b1)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .lvl      (lvl),
        .rise_en  (rise_en),
        .fall_en  (fall_en),
        .irq_mask (irq_mask),
        .clr      (clr),
        .cnt_clr  (cnt_clr),
        .lvl_q    (lvl_q),
        .status   (status),
        .cnt      (cnt),
        .ovf      (ovf),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts edges per channel with plain integers.
    logic [N_CH-1:0] m_lvl;
    logic [N_CH-1:0] m_status;
    logic [N_CH-1:0] m_ovf;
    logic            m_irq;
    int              m_cnt [N_CH];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_lvl    <= '1;
            m_status <= '0;
            m_ovf    <= '0;
            m_irq    <= 1'b0;
            for (int i = 0; i < N_CH; i++) m_cnt[i] <= 0;
        end else begin
            m_irq <= (m_status & irq_mask) != 0;
            for (int i = 0; i < N_CH; i++) begin
                bit changed;
                bit wanted;
                changed = lvl[i] != m_lvl[i];
                wanted  = changed && (lvl[i] ? rise_en[i] : fall_en[i]);
                m_status[i] <= wanted || (m_status[i] && !clr[i]);
                if (cnt_clr[i]) begin
                    m_cnt[i] <= wanted ? 1 : 0;
                    m_ovf[i] <= 1'b0;
                end else if (wanted) begin
                    m_cnt[i] <= (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
                    m_ovf[i] <= m_ovf[i] || (m_cnt[i] == CMAX);
                end
            end
            m_lvl <= lvl;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [N_CH*CNT_W-1:0] exp_cnt;
            for (int i = 0; i < N_CH; i++) exp_cnt[i*CNT_W +: CNT_W] = m_cnt[i][CNT_W-1:0];
            check("cyc_lvl_q",  32'(lvl_q),  32'(m_lvl));
            check("cyc_status", 32'(status), 32'(m_status));
            check("cyc_cnt",    32'(cnt),    32'(exp_cnt));
            check("cyc_ovf",    32'(ovf),    32'(m_ovf));
            check("cyc_irq",    32'(irq),    32'(m_irq));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return cnt[ch*CNT_W +: CNT_W];
    endfunction

    // Clear all sticky state and return enables/masks to idle.
    task automatic cleanup();
        rise_en  = '0;
        fall_en  = '0;
        irq_mask = '0;
        clr      = '1;
        cnt_clr  = '1;
        tick();
        clr     = '0;
        cnt_clr = '0;
        tick();
    endtask

    initial begin
        rstn     = 1'b0;
        lvl      = '1;
        rise_en  = '0;
        fall_en  = '0;
        irq_mask = '0;
        clr      = '0;
        cnt_clr  = '0;
        #22;
        rstn   = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Reset state and first falling edge on channel 0.
        check("rst_status", 32'(status), 32'h0);
        check("rst_cnt",    32'(cnt),    32'h0);
        check("rst_irq",    32'(irq),    32'h0);
        check("rst_lvl_q",  32'(lvl_q),  32'hFF);
        fall_en[0]  = 1'b1;
        irq_mask[0] = 1'b1;
        lvl[0]      = 1'b0;
        tick();
        check("ch0_status", 32'(status[0]), 32'h1);
        check("ch0_cnt",    32'(cnt_of(0)), 32'h1);
        check("ch0_irq_lag", 32'(irq),      32'h0);
        tick();
        check("ch0_irq", 32'(irq), 32'h1);
        cleanup();

        // Channel 3 counts only rising edges across 10 toggles.
        rise_en[3] = 1'b1;
        lvl[3]     = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            lvl[3] = ~lvl[3];
            tick();
        end
        check("ch3_cnt",       32'(cnt_of(3)), 32'd5);
        check("ch3_model_cnt", 32'(m_cnt[3]),  32'd5);
        check("ch3_status",    32'(status[3]), 32'h1);
        cleanup();

        // Set wins over clear; clear alone then drops irq a clock later.
        fall_en[2]  = 1'b1;
        irq_mask[2] = 1'b1;
        lvl[2]      = 1'b0;
        clr[2]      = 1'b1;
        tick();
        check("ch2_set_wins", 32'(status[2]), 32'h1);
        tick();
        check("ch2_cleared", 32'(status[2]), 32'h0);
        check("ch2_irq_hold", 32'(irq), 32'h1);
        clr[2] = 1'b0;
        tick();
        check("ch2_irq_drop", 32'(irq), 32'h0);
        cleanup();

        // Saturation on channel 6 with both edge kinds enabled.
        rise_en[6] = 1'b1;
        fall_en[6] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            lvl[6] = ~lvl[6];
            tick();
        end
        check("ch6_full_cnt", 32'(cnt_of(6)), 32'hF);
        check("ch6_full_ovf", 32'(ovf[6]),    32'h0);
        lvl[6] = ~lvl[6];
        tick();
        check("ch6_sat_cnt", 32'(cnt_of(6)), 32'hF);
        check("ch6_sat_ovf", 32'(ovf[6]),    32'h1);
        check("ch6_model_ovf", 32'(m_ovf[6]), 32'h1);
        lvl[6]     = ~lvl[6];
        cnt_clr[6] = 1'b1;
        tick();
        cnt_clr[6] = 1'b0;
        check("ch6_clr_cnt", 32'(cnt_of(6)), 32'h1);
        check("ch6_clr_ovf", 32'(ovf[6]),    32'h0);
        cleanup();

        // Masked status keeps irq low until the mask opens.
        fall_en[5] = 1'b1;
        lvl[5]     = 1'b0;
        tick();
        check("ch5_status", 32'(status[5]), 32'h1);
        tick();
        check("ch5_masked_irq", 32'(irq), 32'h0);
        irq_mask[5] = 1'b1;
        tick();
        check("ch5_unmasked_irq", 32'(irq), 32'h1);
        cleanup();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            if (c % 32 == 0) begin
                rise_en  = N_CH'($urandom);
                fall_en  = N_CH'($urandom);
                irq_mask = N_CH'($urandom);
            end
            lvl     = lvl ^ (N_CH'($urandom) & N_CH'($urandom));
            clr     = N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom);
            cnt_clr = N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom);
            if (c % 97 == 50) lvl = ~lvl;
            tick();
        end

        // Asynchronous reset between clock edges.
        #2;
        rstn = 1'b0;
        #1;
        check("arst_lvl_q",  32'(lvl_q),  32'hFF);
        check("arst_status", 32'(status), 32'h0);
        check("arst_cnt",    32'(cnt),    32'h0);
        check("arst_ovf",    32'(ovf),    32'h0);
        check("arst_irq",    32'(irq),    32'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        for (int c = 0; c < 300; c++) begin
            if (c % 40 == 0) begin
                rise_en  = N_CH'($urandom);
                fall_en  = N_CH'($urandom);
                irq_mask = N_CH'($urandom);
            end
            lvl     = lvl ^ (N_CH'($urandom) & N_CH'($urandom));
            clr     = N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom);
            cnt_clr = N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom);
            tick();
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/deb_event.md
# deb_event

Multi-channel edge/event capture stage that sits directly downstream of the per-input `deb` debouncers in the AXI4 device. It takes the debounced levels, detects qualified rising and falling edges, and latches them into sticky write-1-to-clear status bits. It also keeps a saturating edge counter per channel and raises a single registered, maskable interrupt toward the AXI register/interrupt logic.

## Interface
Parameters:
- `N_CH`, 8: number of input channels.
- `CNT_W`, 16: width of each per-channel edge counter.
- `RST_VAL`, 1'b1: reset value of the level history. It equals the debouncer's reset output, so no edge is seen when the debouncer releases reset.

Ports. Reset is asynchronous and active-low, one clock.
- `clk`, in, 1: single system clock.
- `rstn`, in, 1: asynchronous active-low reset.
- `lvl`, in, N_CH: debounced levels from `deb.out`, already synchronous to `clk`.
- `rise_en`, in, N_CH: per channel, count and flag rising edges.
- `fall_en`, in, N_CH: per channel, count and flag falling edges.
- `irq_mask`, in, N_CH: 1 means the channel's status contributes to `irq`.
- `clr`, in, N_CH: single-cycle W1C strobe that clears `status[i]`.
- `cnt_clr`, in, N_CH: single-cycle strobe that clears `cnt[i]` and `ovf[i]`.
- `lvl_q`, out, N_CH: registered level history, readable as current input state.
- `status`, out, N_CH: sticky event flags.
- `cnt`, out, N_CH*CNT_W: packed counters; channel i occupies bits [i*CNT_W +: CNT_W].
- `ovf`, out, N_CH: sticky counter-saturation flags.
- `irq`, out, 1: registered OR of `status & irq_mask`.

## Operation
- Every cycle: `lvl_q <= lvl`.
- Rising edge: `lvl[i] & ~lvl_q[i]`. Falling edge: `~lvl[i] & lvl_q[i]`.
- Qualified edge `ev[i]` = `(rise & rise_en[i]) | (fall & fall_en[i])`. Enables are sampled in the edge cycle.
- Status:
  - `ev[i]` sets `status[i]`; `clr[i]` clears it.
  - If both occur in the same cycle, set wins and status stays 1, so no event is lost.
- Counter, in priority order:
  - If `cnt_clr[i]`: `cnt[i]` becomes `ev[i] ? 1 : 0` and `ovf[i]` becomes 0.
  - Else, on `ev[i]`: if `cnt[i]` is all-ones it holds and `ovf[i]` sets; otherwise it increments by 1.
  - The counter never wraps.
- Interrupt: `irq <= |(status & irq_mask)`, using the registered status. A mask change reaches `irq` on the next clock.
- Channels are fully independent. One channel slice carries all per-channel state.

## Timing
- Reset (async assert, sync-released by the upstream reset tree) sets:
  - `lvl_q` = {N_CH{RST_VAL}}
  - `status` = 0, `cnt` = 0, `ovf` = 0, `irq` = 0
- Latencies:
  - `lvl` change at cycle T: `lvl_q`, `status` and `cnt` update on the clock ending T.
  - `irq` asserts one clock later, at T+1.
- `clr` at cycle T: `status` is 0 after the T clock; `irq` deasserts after the T+1 clock, unless another masked channel is still set.
- A toggle every cycle on `lvl` is legal. Each transition is a separate edge, and the count is exact up to saturation.
- Reset mid-operation discards all pending state. After reset, a `lvl` that differs from RST_VAL produces one edge on the first active cycle; this is intended behaviour.
- All enable and mask inputs are quasi-static or register-driven. No handshake exists; the strobes are level-qualified single-cycle pulses, and a strobe held for several cycles simply re-clears every cycle.

## Structure
- Shared package `deb_pkg`:
  - default constants `DEB_N_CH`, `DEB_CNT_W`, `DEB_RST_VAL`.
  - helper function `cnt_slice(i)` that returns the bit offset of channel i in the packed counter.
- Sub-module `deb_event_ch` holds one channel: the level flop, edge qualifier, status, counter and ovf.
- The top generates N_CH instances and the registered irq OR.

## Test plan
- Reset with `lvl` = 8'hFF, then release: `status` = 0, `cnt` = 0, `irq` = 0. Drive `lvl[0]` = 0 with `fall_en[0]` = 1 and `irq_mask[0]` = 1: `status[0]` = 1 one clock later, `cnt[0]` = 1, and `irq` = 1 on the next clock.
- `rise_en[3]` = 1, `fall_en[3]` = 0. Toggle `lvl[3]` 10 times, starting low: `cnt[3]` = 5 and only rising edges are counted.
- `ev[2]` and `clr[2]` in the same cycle: `status[2]` stays 1. `clr[2]` alone one cycle later: `status[2]` = 0, then `irq` = 0 one clock after that.
- Preload by counting with CNT_W = 4. After 15 edges `cnt` = 4'hF and `ovf` = 0. The 16th edge leaves `cnt` = 4'hF and sets `ovf` = 1. Then `cnt_clr` together with an edge gives `cnt` = 1 and `ovf` = 0.
- `status[5]` = 1 with `irq_mask[5]` = 0: `irq` = 0. Set the mask to 1: `irq` = 1 after one clock.
- Assert `rstn` low asynchronously mid-count, between clock edges: all outputs go to reset values immediately, without waiting for a `clk` edge.
